// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial run-length scan controller.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    typedef logic [1:0] mode_t;

    // bit 0 enables zero-run hits, bit 1 enables one-run hits
    localparam mode_t MODE_OFF  = 2'd0;
    localparam mode_t MODE_ZERO = 2'd1;
    localparam mode_t MODE_ONE  = 2'd2;
    localparam mode_t MODE_BOTH = 2'd3;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / result-out handshake bundle for seq_scan_ctrl.
interface seq_scan_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_hit_mask;
    logic [CNT_W-1:0]  out_hit_cnt;

    modport master (
        output in_valid, in_data, in_sof, in_mode, out_ready,
        input  in_ready, out_valid, out_hit_mask, out_hit_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_mode, out_ready,
        output in_ready, out_valid, out_hit_mask, out_hit_cnt
    );

endinterface

// File: rtl/run_detector.sv
// Serial detector flagging RUN_LEN consecutive equal bits; overlapping runs
// keep hitting once the saturating counter reaches RUN_LEN.
module run_detector #(
    parameter int unsigned RUN_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic w,
    output logic hit_zero,
    output logic hit_one
);

    localparam int unsigned   RW      = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

    logic          last_q, last_d;
    logic          hv_q, hv_d;
    logic [RW-1:0] run_q, run_d;
    logic          hit;

    // clr together with en evaluates the bit against an empty history
    always_comb begin
        last_d = last_q;
        hv_d   = hv_q;
        run_d  = run_q;
        hit    = 1'b0;
        if (en) begin
            if (hv_q && !clr && (w == last_q)) begin
                run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
            end else begin
                run_d = RW'(1);
            end
            last_d = w;
            hv_d   = 1'b1;
            hit    = (run_d == RUN_MAX);
        end else if (clr) begin
            hv_d  = 1'b0;
            run_d = '0;
        end
    end

    assign hit_zero = hit && !w;
    assign hit_one  = hit && w;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b0;
            hv_q   <= 1'b0;
            run_q  <= '0;
        end else begin
            last_q <= last_d;
            hv_q   <= hv_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts words, streams them MSB-first through a shared run detector and
// returns a per-bit hit mask plus hit count for each word.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    seq_scan_ctrl_if.slave bus
);

    localparam int unsigned   KW     = $clog2(DATA_W);
    localparam logic [KW-1:0] K_LAST = KW'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic              sof_q;
    mode_t             mode_q;
    logic [KW-1:0]     k_q;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q;

    logic det_en;
    logic det_clr;
    logic hit_zero;
    logic hit_one;
    logic hit_rpt;

    // mask fills from the LSB so the first shifted bit lands on bit DATA_W-1
    always_comb begin
        det_en  = (state_q == SHIFT);
        det_clr = det_en && sof_q && (k_q == '0);
        hit_rpt = (hit_zero && (mode_q == MODE_ZERO || mode_q == MODE_BOTH)) ||
                  (hit_one  && (mode_q == MODE_ONE  || mode_q == MODE_BOTH));
        mask_d  = {mask_q[DATA_W-2:0], hit_rpt};
        cnt_d   = cnt_q + CNT_W'(hit_rpt);
    end

    run_detector #(
        .RUN_LEN (RUN_LEN)
    ) u_det (
        .clk      (clk),
        .reset    (reset),
        .en       (det_en),
        .clr      (det_clr),
        .w        (data_q[DATA_W-1]),
        .hit_zero (hit_zero),
        .hit_one  (hit_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            sof_q       <= 1'b0;
            mode_q      <= MODE_OFF;
            k_q         <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q  <= bus.in_data;
                        sof_q   <= bus.in_sof;
                        mode_q  <= bus.in_mode;
                        k_q     <= '0;
                        mask_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= {data_q[DATA_W-2:0], 1'b0};
                    mask_q <= mask_d;
                    cnt_q  <= cnt_d;
                    k_q    <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_q     <= REPORT;
                        out_valid_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = (state_q == IDLE) && !reset;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_hit_mask = mask_q;
    assign bus.out_hit_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: windowed run model plus directed vectors.
module tb_seq_scan_ctrl;
    import seq_scan_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned RL = 4;
    localparam int unsigned CW = $clog2(DW + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_scan_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    seq_scan_ctrl #(
        .DATA_W  (DW),
        .RUN_LEN (RL),
        .CNT_W   (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    endtask

    // Model: a hit is the last RL bits since the last clear all being equal.
    bit             hist[$];
    bit             armed = 0, m_idle = 1, m_rdy = 0, prev_ov = 0;
    int             m_left = 0;
    logic [DW-1:0]  m_mask;
    int             m_cnt;
    int             n_acc = 0, last_acc = 0, dut_rise = 0;
    int             acc_cyc_q[$];
    logic [DW-1:0]  mdl_mask_q[$], obs_mask_q[$];
    int             mdl_cnt_q[$], obs_cnt_q[$], obs_lat_q[$];

    task automatic scan_word(input logic [DW-1:0] d, input logic s, input logic [1:0] m,
                             output logic [DW-1:0] mask, output int cnt);
        bit b, same;
        mask = '0;
        cnt  = 0;
        if (s) hist.delete();
        for (int i = DW - 1; i >= 0; i--) begin
            b = d[i];
            hist.push_back(b);
            if (hist.size() > RL) void'(hist.pop_front());
            same = (hist.size() == RL);
            foreach (hist[j]) if (hist[j] != b) same = 0;
            if (same && ((!b && (m == MODE_ZERO || m == MODE_BOTH)) ||
                         ( b && (m == MODE_ONE  || m == MODE_BOTH)))) begin
                mask[i] = 1'b1;
                cnt++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", 32'(bus.in_ready), 32'(!reset && m_idle));
            check("out_valid", 32'(bus.out_valid), 32'(m_rdy));
            if (m_rdy) begin
                check("mdl_mask", 32'(bus.out_hit_mask), 32'(m_mask));
                check("mdl_cnt", 32'(bus.out_hit_cnt), 32'(m_cnt));
            end
            if (bus.out_valid && !prev_ov) dut_rise = cyc;
        end
        prev_ov = bus.out_valid;
        if (reset) begin
            armed  = 1;
            m_idle = 1;
            m_rdy  = 0;
            m_left = 0;
            hist.delete();
        end else if (armed) begin
            if (m_idle) begin
                if (bus.in_valid) begin
                    scan_word(bus.in_data, bus.in_sof, bus.in_mode, m_mask, m_cnt);
                    mdl_mask_q.push_back(m_mask);
                    mdl_cnt_q.push_back(m_cnt);
                    acc_cyc_q.push_back(cyc);
                    last_acc = cyc;
                    n_acc++;
                    m_idle = 0;
                    m_left = DW;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_rdy = 1;
            end else if (m_rdy && bus.out_ready) begin
                obs_mask_q.push_back(bus.out_hit_mask);
                obs_cnt_q.push_back(int'(bus.out_hit_cnt));
                obs_lat_q.push_back(dut_rise - last_acc);
                m_rdy  = 0;
                m_idle = 1;
            end
        end
    end

    // Driver tasks are entered and left just after a rising edge.
    task automatic send(input logic [DW-1:0] d, input logic s, input logic [1:0] m);
        int n0 = n_acc;
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = s;
        bus.in_mode  = m;
        while (n_acc == n0 && w < 40) begin
            @(posedge clk); #1; w++;
        end
        bus.in_valid = 1'b0;
        check("accepted", 32'(n_acc - n0), 32'd1);
    endtask

    task automatic get_result(input string nm, input logic [DW-1:0] xm, input int xc);
        int w = 0;
        while (obs_mask_q.size() == 0 && w < 40) begin
            @(posedge clk); #1; w++;
        end
        check({nm, "_present"}, 32'(obs_mask_q.size() != 0), 32'd1);
        if (obs_mask_q.size() != 0) begin
            check({nm, "_mask"}, 32'(obs_mask_q.pop_front()), 32'(xm));
            check({nm, "_cnt"}, 32'(obs_cnt_q.pop_front()), 32'(xc));
            check({nm, "_lat"}, 32'(obs_lat_q.pop_front()), 32'(DW + 1));
        end
        check({nm, "_model_present"}, 32'(mdl_mask_q.size() != 0), 32'd1);
        if (mdl_mask_q.size() != 0) begin
            check({nm, "_model_mask"}, 32'(mdl_mask_q.pop_front()), 32'(xm));
            check({nm, "_model_cnt"}, 32'(mdl_cnt_q.pop_front()), 32'(xc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, w, sz;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.in_mode   = MODE_OFF;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mask", 32'(bus.out_hit_mask), 32'd0);
        check("rst_cnt", 32'(bus.out_hit_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // 1. split word
        send(8'h0F, 1'b1, MODE_BOTH);
        get_result("t1", 8'h11, 2);

        // 2. runs straddling a word boundary
        send(8'hFF, 1'b1, MODE_BOTH);
        get_result("t2a", 8'h1F, 5);
        send(8'hF0, 1'b0, MODE_BOTH);
        get_result("t2b", 8'hF1, 5);
        send(8'hF0, 1'b1, MODE_BOTH);
        get_result("t2c", 8'h11, 2);

        // 3. mode filtering, history advances in mode 0
        send(8'h0F, 1'b1, MODE_ONE);
        get_result("t3_one", 8'h01, 1);
        send(8'h0F, 1'b1, MODE_ZERO);
        get_result("t3_zero", 8'h10, 1);
        send(8'h0F, 1'b1, MODE_OFF);
        get_result("t3_off", 8'h00, 0);
        send(8'hFF, 1'b0, MODE_BOTH);
        get_result("t3_next", 8'hFF, 8);

        // 4. backpressure in REPORT
        bus.out_ready = 1'b0;
        send(8'h0F, 1'b1, MODE_BOTH);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("bp_reached_report", 32'(bus.out_valid), 32'd1);
        n0 = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        bus.in_sof   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_mask", 32'(bus.out_hit_mask), 32'h11);
            check("bp_cnt", 32'(bus.out_hit_cnt), 32'd2);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_no_accept", 32'(n_acc - n0), 32'd0);
        @(posedge clk); #1;
        get_result("t4", 8'h11, 2);

        // 5. reset at SHIFT bit k=3
        send(8'h00, 1'b1, MODE_BOTH);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("rs_no_result", 32'(obs_mask_q.size()), 32'd0);
        check("rs_model_pending", 32'(mdl_mask_q.size()), 32'd1);
        if (mdl_mask_q.size() != 0) begin
            check("rs_model_mask", 32'(mdl_mask_q.pop_front()), 32'h1F);
            void'(mdl_cnt_q.pop_front());
        end
        send(8'h00, 1'b0, MODE_BOTH);
        get_result("t5", 8'h1F, 5);

        // 6. back-to-back words
        n0 = n_acc;
        bus.in_valid = 1'b1;
        bus.in_mode  = MODE_BOTH;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = (i == 0) ? 8'h0F : (i == 1) ? 8'hF0 : 8'h33;
            bus.in_sof  = (i == 0);
            w = 0;
            while (n_acc == n0 + i && w < 30) begin
                @(posedge clk); #1; w++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc - n0), 32'd3);
        sz = acc_cyc_q.size();
        if (sz >= 3) begin
            check("b2b_gap1", 32'(acc_cyc_q[sz-2] - acc_cyc_q[sz-3]), 32'd10);
            check("b2b_gap2", 32'(acc_cyc_q[sz-1] - acc_cyc_q[sz-2]), 32'd10);
        end
        get_result("t6a", 8'h11, 2);
        get_result("t6b", 8'hF1, 5);
        get_result("t6c", 8'hC0, 2);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Scheduler that accepts parallel words over a valid/ready handshake and serialises them MSB-first, one bit per cycle, into a run-length detector.
- The detector flags RUN_LEN consecutive equal bits; overlapping runs are detected.
- The block collects a per-bit hit mask and a hit count, then returns one result per word over a valid/ready handshake.
- Sits between a word-oriented producer and the serial detector, sequencing and sharing the detector across a stream of words.

Parameters:
- DATA_W, 8, input word width; ≥2.
- RUN_LEN, 4, run length that produces a hit; legal range 2..16.
- CNT_W, $clog2(DATA_W+1), width of the hit count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  word to scan; bit DATA_W-1 is shifted first.
- in_sof  in  1  start of frame: clear detector history before the first bit of this word.
- in_mode  in  2  0 = disabled, 1 = zero-runs only, 2 = one-runs only, 3 = both.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_hit_mask  out  DATA_W  bit i set if a reported hit completed on in_data[i].
- out_hit_cnt  out  CNT_W  popcount of out_hit_mask.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after. out_valid=0, out_hit_mask=0, out_hit_cnt=0. FSM is in IDLE and detector history is cleared.
- FSM states are IDLE, SHIFT and REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data, in_sof and in_mode; clear the mask and count; bit index k=0; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, present bit in_data[DATA_W-1-k] to the detector and record the hit into mask bit DATA_W-1-k.
  - Increment k; after k=DATA_W-1, go to REPORT.
  - SHIFT lasts exactly DATA_W cycles.
  - If in_sof was captured, history is cleared in the first SHIFT cycle, before that bit is evaluated.
- REPORT:
  - out_valid=1; mask and count are stable.
  - On out_ready, go to IDLE.
  - While out_ready=0, hold all outputs; in_valid is ignored.
- Latency: with the accept in cycle 0, out_valid rises in cycle DATA_W+1. Minimum initiation interval is DATA_W+2 cycles.
- Detector state:
  - Tracks last bit, a history-valid flag, and a run counter that saturates at RUN_LEN.
  - Bit equal to last bit with history valid: counter+1, saturating.
  - Otherwise: counter=1 and last bit = the new bit.
  - Hit when the counter equals RUN_LEN after the update, so runs longer than RUN_LEN hit on every further bit.
  - hit_zero = hit and bit==0; hit_one = hit and bit==1.
- Mode:
  - The reported hit is hit_zero&mode[0] | hit_one&mode[1].
  - History is updated in every mode, including mode 0.
- History persists across words unless in_sof=1 or reset. Runs straddling word boundaries are detected, and the hit is credited to the bit that completes the run.
- Reset mid-operation: the next state is IDLE with history cleared and out_valid=0. The partial result is discarded and not reported.
- Count arithmetic is unsigned; the count cannot overflow because CNT_W holds DATA_W.

Decomposition:
- Package seq_scan_pkg holds:
  - state enum (IDLE/SHIFT/REPORT);
  - mode constants MODE_OFF, MODE_ZERO, MODE_ONE, MODE_BOTH.
- Sub-module run_detector:
  - inputs clk, reset, en, clr, w;
  - outputs hit_zero, hit_one;
  - parameter RUN_LEN;
  - combinational hit derived from the pre-update state and w.
- seq_scan_ctrl holds the FSM, shift register, bit counter, mask and count.

Test Plan:
(DATA_W=8, RUN_LEN=4)
1. Basic split word: in_data=8'h0F, sof=1, mode=3.
   -> out_valid in cycle 9 after accept, mask=8'h11, cnt=2.
2. Runs straddling a boundary: 8'hFF (sof=1, mode=3), then 8'hF0 (sof=0).
   -> First mask=8'h1F, cnt=5; second mask=8'hF1, cnt=5.
   Repeat the second word with sof=1 -> mask=8'h11, cnt=2.
3. Mode filtering: 8'h0F, sof=1.
   -> mode=2: mask=8'h01.
   -> mode=1: mask=8'h10.
   -> mode=0: mask=8'h00, cnt=0, and history still advances (next word 8'hFF with sof=0 gives mask=8'hFF).
4. Backpressure: out_ready=0 for 5 cycles in REPORT with in_valid=1.
   -> out_valid stays 1, mask and count unchanged, in_ready=0, no word accepted.
   On out_ready=1: IDLE, in_ready=1 next cycle.
5. Reset mid-scan: 8'h00 with sof=1; assert reset at SHIFT bit k=3.
   -> Next cycle IDLE, out_valid=0, in_ready=1, no result emitted.
   Then 8'h00 with sof=0 -> mask=8'h1F, cnt=5 (history was cleared).
6. Back-to-back words: in_valid held high and out_ready=1, three words.
   -> Accepts spaced exactly 10 cycles apart; results in order.
